// File: rtl/heap_deque_secondary_mux_if.sv
// heap_deque_secondary_mux_if: channel-side and heap-side signals of the secondary dequeue mux
interface heap_deque_secondary_mux_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int VW = 64,
  parameter int PW = 10
);
  logic [NUM_CHANNELS-1:0] ch_req_en, ch_req_ready, ch_out_valid, ch_out_en;
  logic [NUM_CHANNELS*VW-1:0] ch_out_value;
  logic [NUM_CHANNELS*PW-1:0] ch_out_priority;
  logic heap_req_en, heap_req_ready, heap_resp_ready, heap_resp_en, heap_ready;
  logic [VW-1:0] heap_resp_value;
  logic [PW-1:0] heap_resp_priority;
  modport slave (
    input ch_req_en, ch_out_en, heap_req_ready, heap_resp_ready, heap_resp_value,
      heap_resp_priority, heap_ready,
    output ch_req_ready, ch_out_valid, ch_out_value, ch_out_priority, heap_req_en, heap_resp_en
  );
  modport master (
    output ch_req_en, ch_out_en, heap_req_ready, heap_resp_ready, heap_resp_value,
      heap_resp_priority, heap_ready,
    input ch_req_ready, ch_out_valid, ch_out_value, ch_out_priority, heap_req_en, heap_resp_en
  );
endinterface

// File: rtl/heap_deque_secondary_mux.sv
// heap_deque_secondary_mux: round-robin N-channel front end for the heap deque-secondary port
module heap_deque_secondary_mux #(
  parameter int NUM_CHANNELS = 4,
  parameter int HEAP_ENTRY_VALUE_WIDTH = 64,
  parameter int HEAP_PRIORITY_AWIDTH = 10,
  parameter int MAX_INFLIGHT = 8,
  parameter int MAX_PER_CHANNEL = 2
) (
  input  logic clk,
  input  logic rst,
  heap_deque_secondary_mux_if.slave bus,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_count,
  output logic orphan_resp
);
  localparam int N = NUM_CHANNELS;
  localparam int VW = HEAP_ENTRY_VALUE_WIDTH;
  localparam int PW = HEAP_PRIORITY_AWIDTH;
  localparam int CW = $clog2(N);
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int OW = $clog2(MAX_PER_CHANNEL + 1);
  logic [N-1:0] pending, slot_valid, pop;
  logic [OW-1:0] outstanding [N];
  logic [VW-1:0] slot_value [N];
  logic [PW-1:0] slot_prio [N];
  logic [CW-1:0] tag_mem [MAX_INFLIGHT];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] rr, gnt, head;
  logic grant, deliver, drain, tag_full, tag_empty;
  int idx;
  assign tag_full = inflight_count == IW'(MAX_INFLIGHT);
  assign tag_empty = inflight_count == '0;
  assign head = tag_mem[rd_ptr];
  // Round-robin pick: first pending channel at or after rr, wrapping; the response head routes by tag
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % N;
      gnt = pending[idx] ? CW'(idx) : gnt;
    end
    grant = !rst && bus.heap_req_ready && !tag_full && |pending;
    deliver = !rst && bus.heap_resp_ready && !tag_empty && !slot_valid[head];
    drain = !rst && bus.heap_resp_ready && tag_empty;
  end
  // Channel-facing and heap-facing outputs
  always_comb begin
    bus.ch_req_ready = '0;
    bus.ch_out_value = '0;
    bus.ch_out_priority = '0;
    pop = bus.ch_out_en & slot_valid;
    for (int i = 0; i < N; i++) begin
      bus.ch_req_ready[i] = !rst && bus.heap_ready && !pending[i] && (outstanding[i] < OW'(MAX_PER_CHANNEL));
      bus.ch_out_value[i*VW +: VW] = slot_value[i];
      bus.ch_out_priority[i*PW +: PW] = slot_prio[i];
    end
    bus.ch_out_valid = slot_valid;
    bus.heap_req_en = grant;
    bus.heap_resp_en = deliver || drain;
  end
  // Control state: pending requests, per-channel credit, slot occupancy, tag pointers, rr, orphan flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      slot_valid <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      inflight_count <= '0;
      rr <= '0;
      orphan_resp <= 1'b0;
      for (int i = 0; i < N; i++) outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        pending[i] <= (pending[i] || (bus.ch_req_en[i] && bus.ch_req_ready[i])) && !(grant && gnt == CW'(i));
        outstanding[i] <= outstanding[i] + OW'(grant && gnt == CW'(i)) - OW'(pop[i]);
        slot_valid[i] <= (slot_valid[i] && !pop[i]) || (deliver && head == CW'(i));
      end
      wr_ptr <= wr_ptr + AW'(grant);
      rd_ptr <= rd_ptr + AW'(deliver);
      inflight_count <= inflight_count + IW'(grant) - IW'(deliver);
      rr <= !grant ? rr : (gnt == CW'(N - 1)) ? '0 : gnt + CW'(1);
      orphan_resp <= orphan_resp || drain;
    end
  end
  // Datapath storage: issued channel tags and response slots
  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= gnt;
    for (int i = 0; i < N; i++) begin
      if (deliver && head == CW'(i)) begin
        slot_value[i] <= bus.heap_resp_value;
        slot_prio[i] <= bus.heap_resp_priority;
      end
    end
  end
endmodule
